// File: rtl/matcher_pkg.sv
// Shared definitions for the matcher list ROM and its scanner.
// The scanner state encoding and default bus widths live here.
package matcher_pkg;

  localparam int DEF_LIST_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/matcher_list_scanner_if.sv
// Control and ROM-read bundle between the matcher control logic, the list scanner and the list ROM.
// The slave modport is the scanner side; the master modport is the control/ROM side.
interface matcher_list_scanner_if
  import matcher_pkg::*;
#(
  parameter int LIST_WIDTH = DEF_LIST_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  start;
  logic [DATA_WIDTH-1:0] key;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [LIST_WIDTH-1:0] match_idx;
  logic                  rom_enable;
  logic [LIST_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  start, key, rom_data,
    output busy, done, found, match_idx, rom_enable, rom_addr
  );

  modport master (
    output start, key, rom_data,
    input  busy, done, found, match_idx, rom_enable, rom_addr
  );

endinterface

// File: rtl/matcher_list_scanner.sv
// Walks the list ROM one address per cycle after a start pulse and reports the first entry equal to the latched key.
// Compare runs two cycles behind the accept edge: one for the address register, one for the ROM read.
module matcher_list_scanner
  import matcher_pkg::*;
#(
  parameter int LIST_WIDTH     = DEF_LIST_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LIST_DEPTH     = 1024,
  parameter int USE_TERMINATOR = 1
) (
  input  logic                   fclk,
  input  logic                   rst,
  matcher_list_scanner_if.slave  bus
);

  localparam logic [LIST_WIDTH-1:0] LAST_ADDR = LIST_WIDTH'(LIST_DEPTH - 1);
  localparam logic [LIST_WIDTH:0]   LAST_IDX  = (LIST_WIDTH + 1)'(LIST_DEPTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_key;
  logic [LIST_WIDTH-1:0] r_addr;
  logic                  r_cmp_valid;
  logic [LIST_WIDTH:0]   r_cmp_idx;
  logic                  r_done;
  logic                  r_found;
  logic [LIST_WIDTH-1:0] r_match_idx;

  logic w_accept;
  logic w_hit;
  logic w_term;
  logic w_last;
  logic w_finish;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  // A hit is checked ahead of the terminator so a zero key can match a zero entry.
  assign w_hit    = r_cmp_valid && (bus.rom_data == r_key);
  assign w_term   = r_cmp_valid && (USE_TERMINATOR != 0) && (bus.rom_data == '0);
  assign w_last   = r_cmp_valid && (r_cmp_idx == LAST_IDX);
  assign w_finish = (r_state == ST_SCAN) && (w_hit || w_term || w_last);

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_SCAN;
      ST_SCAN: if (w_finish)  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (r_state == ST_SCAN);
    bus.rom_enable = (r_state == ST_SCAN);
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      r_key       <= '0;
      r_addr      <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= '0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_match_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_key       <= bus.key;
        r_addr      <= '0;
        r_cmp_valid <= 1'b0;
        r_cmp_idx   <= '0;
        r_found     <= 1'b0;
        r_match_idx <= '0;
      end else if (r_state == ST_SCAN) begin
        r_cmp_valid <= 1'b1;
        if (r_addr != LAST_ADDR) begin
          r_addr <= r_addr + LIST_WIDTH'(1);
        end
        if (w_finish) begin
          r_done      <= 1'b1;
          r_cmp_valid <= 1'b0;
          r_found     <= w_hit;
          r_match_idx <= w_hit ? r_cmp_idx[LIST_WIDTH-1:0] : '0;
        end else if (r_cmp_valid) begin
          r_cmp_idx <= r_cmp_idx + (LIST_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign bus.done      = r_done;
  assign bus.found     = r_found;
  assign bus.match_idx = r_match_idx;
  assign bus.rom_addr  = r_addr;

endmodule

// File: doc/matcher_list_scanner.md
# matcher_list_scanner

Read-side sequencer for the matcher's list ROM (`matcher_list_rom`). On a start pulse it latches a search key and walks the ROM one address per cycle. It compares each returned entry against the key and reports the first matching index, or a miss. It sits between the GPIO-driven control logic and the list ROM, and is the only initiator of ROM reads.

## Interface
Parameters:
- `LIST_WIDTH`, default 10: ROM address width.
- `DATA_WIDTH`, default 64: entry and key width.
- `LIST_DEPTH`, default 1024: number of entries scanned; must satisfy 1 ≤ `LIST_DEPTH` ≤ 2**`LIST_WIDTH`.
- `USE_TERMINATOR`, default 1: when 1, an all-zero entry ends the list as a miss.

Ports:
- `fclk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `key`  in  `DATA_WIDTH`  search key; latched on accepted `start`.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when a scan finishes.
- `found`  out  1  result of the last scan; valid from `done` until the next accepted `start`.
- `match_idx`  out  `LIST_WIDTH`  index of the first match; 0 on a miss.
- `rom_enable`  out  1  to ROM `enable`.
- `rom_addr`  out  `LIST_WIDTH`  to ROM `addr`.
- `rom_data`  in  `DATA_WIDTH`  from ROM `data_out`; arrives one cycle after the address.

## Operation
The block has two states, IDLE and SCAN.

IDLE:
- `rom_enable` = 0 and `busy` = 0.
- On `start` = 1:
  - latch `key` into `key_q`;
  - set `rom_addr` = 0 and `rom_enable` = 1;
  - clear `found` and `match_idx`;
  - go to SCAN.

SCAN:
- Address issue:
  - Each cycle, `rom_addr` increments by 1 until it reaches `LIST_DEPTH`-1, then holds.
  - `rom_addr` never wraps.
  - `rom_enable` stays 1 for the whole scan.
- Compare pipeline:
  - An internal `cmp_valid` flag marks the cycle in which `rom_data` belongs to an issued address.
  - The matching index is tracked in `cmp_idx`, a counter of width `LIST_WIDTH`+1.
  - `cmp_valid` goes high one cycle after entering SCAN.
- Per valid compare, evaluated in priority order:
  1. `rom_data` == `key_q`: set `found` = 1, `match_idx` = `cmp_idx`, pulse `done`, go to IDLE.
  2. `USE_TERMINATOR` and `rom_data` == 0: `found` = 0, `match_idx` = 0, pulse `done`, go to IDLE.
  3. `cmp_idx` == `LIST_DEPTH`-1: miss; same outputs as rule 2.
  4. Otherwise increment `cmp_idx`.
- Rule 1 takes priority over rule 2, so a key of 0 matches a zero entry rather than terminating.
- On leaving SCAN, `rom_enable` goes to 0 in the same edge.
- `start` during SCAN is ignored, and changes to `key` after latching are ignored.

Reset:
- `rst` forces IDLE.
- All outputs reset to 0: `busy`, `done`, `found`, `match_idx`, `rom_enable`, `rom_addr`.
- The same applies mid-scan: the scan is abandoned, no `done` pulse is produced, and there is no pending state afterwards.

## Timing
- Accept edge T0: `start` sampled high in IDLE; `busy` and `rom_enable` are high after T0.
- Data path: the address for entry i is presented after edge T0+i. `rom_data` = list[i] is visible after edge T0+i+1 and is compared at edge T0+i+2.
- Result latency:
  - Match or terminator at index i: `done` is high in the cycle after edge T0+i+2, and `busy` falls at that same edge.
  - Full miss: `done` follows edge T0+`LIST_DEPTH`+1.
- Throughput: one entry per cycle. Minimum start-to-start spacing is latency+1 (a `start` coinciding with the `done` cycle is accepted, since the block is back in IDLE).
- `done` is exactly one cycle wide. `found` and `match_idx` are registered and stable from the `done` cycle until the next accepted `start`.
- `LIST_DEPTH` = 1: one compare at T0+2, then finish.

## Structure
- Shared package or include file `matcher_pkg`:
  - state encoding (IDLE = 1'b0, SCAN = 1'b1);
  - default `LIST_WIDTH` and `DATA_WIDTH` constants, also consumed by `matcher_list_rom`.
- No sub-module. The comparator is a single equality expression, and the address and compare counters are local.
- Top level and bench instantiate `matcher_list_scanner` alongside `matcher_list_rom` with matching parameters.

## Test plan
Benches use `LIST_WIDTH`=4 and `LIST_DEPTH`=16, with ROM loaded 0x11, 0x22, … 0xFF at indices 0–14 and 0x00 at index 15 unless stated otherwise.
- Key 0x33 with `USE_TERMINATOR`=1 -> `done` after T0+4, `found`=1, `match_idx`=2, `rom_enable` low in the `done` cycle.
- Key 0x11 -> `done` after T0+2, `found`=1, `match_idx`=0.
- Key 0xAB, ROM has no zero entry (index 15 = 0x99), `USE_TERMINATOR`=1 -> `done` after T0+17, `found`=0, `match_idx`=0; `rom_addr` holds at 15 during cycles T0+15..T0+16.
- Key 0xAB with a zero at index 5 -> `done` after T0+7 with `found`=0; with `USE_TERMINATOR`=0, `done` occurs after T0+17 instead.
- `start` pulsed again during a scan, and `key` changed mid-scan -> no effect; the result matches the originally latched key.
- `rst` asserted at T0+5 during a scan -> all outputs 0 after that edge and no `done` pulse. A new `start` at T0+8 with key 0x22 -> `done` after T0+11, `match_idx`=1.
